// File: rtl/axi_master_if_if.sv
// AXI4 master-port bundle for axi_master_if: the AW/W/B/AR/R channels.
// master drives address, write data and response-ready; slave drives the rest.
interface axi_master_if_if;
   logic [7:0]  AWID_M;
   logic [31:0] AWADDR_M;
   logic [3:0]  AWLEN_M;
   logic [2:0]  AWSIZE_M;
   logic [1:0]  AWBURST_M;
   logic        AWVALID_M;
   logic        AWREADY_M;

   logic [31:0] WDATA_M;
   logic [3:0]  WSTRB_M;
   logic        WLAST_M;
   logic        WVALID_M;
   logic        WREADY_M;

   logic [7:0]  BID_M;
   logic [1:0]  BRESP_M;
   logic        BVALID_M;
   logic        BREADY_M;

   logic [7:0]  ARID_M;
   logic [31:0] ARADDR_M;
   logic [3:0]  ARLEN_M;
   logic [2:0]  ARSIZE_M;
   logic [1:0]  ARBURST_M;
   logic        ARVALID_M;
   logic        ARREADY_M;

   logic [7:0]  RID_M;
   logic [31:0] RDATA_M;
   logic [1:0]  RRESP_M;
   logic        RLAST_M;
   logic        RVALID_M;
   logic        RREADY_M;

   modport master (
      output AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
      input  AWREADY_M,
      output WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
      input  WREADY_M,
      input  BID_M, BRESP_M, BVALID_M,
      output BREADY_M,
      output ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
      input  ARREADY_M,
      input  RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
      output RREADY_M
   );

   modport slave (
      input  AWID_M, AWADDR_M, AWLEN_M, AWSIZE_M, AWBURST_M, AWVALID_M,
      output AWREADY_M,
      input  WDATA_M, WSTRB_M, WLAST_M, WVALID_M,
      output WREADY_M,
      output BID_M, BRESP_M, BVALID_M,
      input  BREADY_M,
      input  ARID_M, ARADDR_M, ARLEN_M, ARSIZE_M, ARBURST_M, ARVALID_M,
      output ARREADY_M,
      output RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M,
      input  RREADY_M
   );
endinterface

// File: rtl/axi_master_if.sv
// AXI4 master bridge: turns one request/stream transaction at a time into an
// INCR burst of 32-bit beats, with a handshake-progress timeout as a debug aid.
module axi_master_if #(
   parameter logic [3:0] MASTER_ID = 4'd0,
   parameter logic [7:0] TIMEOUT   = 8'd255
) (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [3:0]  req_len,
   input  logic [31:0] wr_data,
   input  logic [3:0]  wr_strb,
   input  logic        wr_valid,
   output logic        wr_ready,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        rd_last,
   input  logic        rd_ready,
   output logic        done,
   output logic        resp_err,
   axi_master_if_if.master axi
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_AR,
      S_R,
      S_AW,
      S_W,
      S_B,
      S_DONE
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [31:0] addr_q;
   logic [3:0]  len_q;
   logic [3:0]  beat_cnt;
   logic        err_q;
   logic [7:0]  timer_q;

   logic        accept;
   logic        r_hs;
   logic        w_hs;
   logic        b_hs;
   logic        any_hs;
   logic        timeout_hit;
   logic        timeout_abort;
   logic        busy;

   // Response IDs are not checked against the issued ID.
   logic        unused_ids;
   assign unused_ids = ^{axi.RID_M, axi.BID_M};

   assign timeout_hit = (timer_q == (TIMEOUT - 8'd1));
   assign busy        = (state == S_AR) || (state == S_R) || (state == S_AW) ||
                        (state == S_W)  || (state == S_B);

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Channel outputs follow the current state; only the active channel is driven.
   always_comb begin
      state_next     = state;
      accept         = 1'b0;
      r_hs           = 1'b0;
      w_hs           = 1'b0;
      b_hs           = 1'b0;
      any_hs         = 1'b0;
      timeout_abort  = 1'b0;

      req_ready      = 1'b0;
      wr_ready       = 1'b0;
      rd_data        = 32'd0;
      rd_valid       = 1'b0;
      rd_last        = 1'b0;
      done           = 1'b0;
      resp_err       = 1'b0;

      axi.AWID_M     = {4'd0, MASTER_ID};
      axi.AWADDR_M   = addr_q;
      axi.AWLEN_M    = len_q;
      axi.AWSIZE_M   = 3'b010;
      axi.AWBURST_M  = 2'b01;
      axi.AWVALID_M  = 1'b0;
      axi.WDATA_M    = 32'd0;
      axi.WSTRB_M    = 4'd0;
      axi.WLAST_M    = 1'b0;
      axi.WVALID_M   = 1'b0;
      axi.BREADY_M   = 1'b0;
      axi.ARID_M     = {4'd0, MASTER_ID};
      axi.ARADDR_M   = addr_q;
      axi.ARLEN_M    = len_q;
      axi.ARSIZE_M   = 3'b010;
      axi.ARBURST_M  = 2'b01;
      axi.ARVALID_M  = 1'b0;
      axi.RREADY_M   = 1'b0;

      case (state)
         S_IDLE: begin
            req_ready = ~ARESET;
            accept    = req_valid & ~ARESET;
            if (accept) begin
               state_next = req_write ? S_AW : S_AR;
            end
         end
         S_AR: begin
            axi.ARVALID_M = 1'b1;
            if (axi.ARREADY_M) begin
               any_hs     = 1'b1;
               state_next = S_R;
            end else if (timeout_hit) begin
               timeout_abort = 1'b1;
               state_next    = S_DONE;
            end
         end
         S_R: begin
            axi.RREADY_M = rd_ready;
            rd_valid     = axi.RVALID_M;
            rd_data      = axi.RDATA_M;
            rd_last      = axi.RLAST_M;
            r_hs         = axi.RVALID_M & rd_ready;
            if (r_hs) begin
               any_hs = 1'b1;
               if (axi.RLAST_M) begin
                  state_next = S_DONE;
               end
            end else if (timeout_hit) begin
               timeout_abort = 1'b1;
               state_next    = S_DONE;
            end
         end
         S_AW: begin
            axi.AWVALID_M = 1'b1;
            if (axi.AWREADY_M) begin
               any_hs     = 1'b1;
               state_next = S_W;
            end else if (timeout_hit) begin
               timeout_abort = 1'b1;
               state_next    = S_DONE;
            end
         end
         S_W: begin
            axi.WVALID_M = wr_valid;
            axi.WDATA_M  = wr_data;
            axi.WSTRB_M  = wr_strb;
            axi.WLAST_M  = (beat_cnt == len_q);
            wr_ready     = axi.WREADY_M;
            w_hs         = wr_valid & axi.WREADY_M;
            if (w_hs) begin
               any_hs = 1'b1;
               if (beat_cnt == len_q) begin
                  state_next = S_B;
               end
            end else if (timeout_hit) begin
               timeout_abort = 1'b1;
               state_next    = S_DONE;
            end
         end
         S_B: begin
            axi.BREADY_M = 1'b1;
            b_hs         = axi.BVALID_M;
            if (b_hs) begin
               any_hs     = 1'b1;
               state_next = S_DONE;
            end else if (timeout_hit) begin
               timeout_abort = 1'b1;
               state_next    = S_DONE;
            end
         end
         S_DONE: begin
            done       = 1'b1;
            resp_err   = err_q;
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Request latch, beat counter, sticky error flag and the progress timer.
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         addr_q   <= 32'd0;
         len_q    <= 4'd0;
         beat_cnt <= 4'd0;
         err_q    <= 1'b0;
         timer_q  <= 8'd0;
      end else begin
         if (accept) begin
            addr_q   <= req_addr;
            len_q    <= req_len;
            beat_cnt <= 4'd0;
            err_q    <= 1'b0;
         end
         if (r_hs) begin
            beat_cnt <= beat_cnt + 4'd1;
            err_q    <= err_q | (axi.RRESP_M != 2'b00);
         end
         if (w_hs) begin
            beat_cnt <= beat_cnt + 4'd1;
         end
         if (b_hs) begin
            err_q <= err_q | (axi.BRESP_M != 2'b00);
         end
         if (timeout_abort) begin
            err_q <= 1'b1;
         end
         // Timer restarts on every state change so each phase gets a full budget.
         if ((state_next != state) || any_hs) begin
            timer_q <= 8'd0;
         end else if (busy) begin
            timer_q <= timer_q + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_axi_master_if.sv
// Directed bench for axi_master_if: table of zero-wait transactions plus
// hand-written backpressure, toggling-WREADY, timeout and reset sequences.
module tb_axi_master_if;

   localparam logic [31:0] R_BASE = 32'hDEAD_BEEF;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [3:0]  req_len;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        rd_last;
   logic        rd_ready;
   logic        done;
   logic        resp_err;

   axi_master_if_if bus ();

   axi_master_if #(.MASTER_ID(4'd3), .TIMEOUT(8'd8)) dut (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .wr_data   (wr_data),
      .wr_strb   (wr_strb),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_last   (rd_last),
      .rd_ready  (rd_ready),
      .done      (done),
      .resp_err  (resp_err),
      .axi       (bus)
   );

   always #5 ACLK = ~ACLK;

   int n_checks = 0;
   int n_fail   = 0;

   // Slave and requester model configuration/state
   int          ar_delay, aw_delay, ar_wait_cnt, aw_wait_cnt;
   bit          aw_never, wready_toggle;
   logic [1:0]  rresp_cfg, bresp_cfg;
   int          r_pending, r_idx, r_consumed;
   bit          w_active, w_phase, b_pending;
   int          wr_idx, wr_total;
   int          stall_after, stall_left;

   // Observation state
   int          cyc, accept_cyc, done_cyc, done_cnt;
   bit          accept_seen, done_err, done_awvalid;
   logic [31:0] addr_seen;
   logic [3:0]  len_seen;
   logic [31:0] beat_data_q[$];
   bit          beat_last_q[$];
   logic [3:0]  strb_and;
   int          ar_stab_viol, rr_viol, wv_viol, bready_viol;
   bit          ar_pend_prev;
   logic [31:0] ar_addr_prev;
   logic [3:0]  ar_len_prev;

   typedef struct {
      bit          write;
      logic [31:0] addr;
      logic [3:0]  len;
      logic [1:0]  rresp;
      logic [1:0]  bresp;
      bit          exp_err;
      int          exp_lat;
      logic [31:0] exp_last;
   } txn_vec_t;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic clearSlave();
      ar_delay = 0; aw_delay = 0; ar_wait_cnt = 0; aw_wait_cnt = 0;
      aw_never = 0; wready_toggle = 0; rresp_cfg = 2'b00; bresp_cfg = 2'b00;
      r_pending = 0; r_idx = 0; r_consumed = 0;
      w_active = 0; b_pending = 0;
      wr_idx = 0; wr_total = 0;
      stall_after = -1; stall_left = 0;
      beat_data_q.delete(); beat_last_q.delete();
      strb_and = 4'hF;
      ar_stab_viol = 0; rr_viol = 0; wv_viol = 0; bready_viol = 0;
   endtask

   task automatic applyStimulus(input bit write, input logic [31:0] addr, input logic [3:0] len);
      int n;
      @(negedge ACLK);
      accept_seen = 0;
      req_valid   = 1'b1;
      req_write   = write;
      req_addr    = addr;
      req_len     = len;
      wr_idx      = 0;
      wr_total    = write ? int'(len) + 1 : 0;
      n = 0;
      do begin
         @(negedge ACLK);
         n++;
      end while (!accept_seen && n < 20);
      req_valid = 1'b0;
      checkOutput("request_accepted", 32'(accept_seen), 32'd1);
   endtask

   task automatic waitDone(input int start_cnt, output bit got_done, output int lat);
      int n;
      n = 0;
      while (done_cnt == start_cnt && n < 200) begin
         @(negedge ACLK);
         n++;
      end
      got_done = (done_cnt != start_cnt);
      lat      = done_cyc - accept_cyc;
   endtask

   // Slave and requester drivers: all inputs change on the falling edge.
   initial begin
      bus.AWREADY_M = 0; bus.WREADY_M = 0;
      bus.BID_M = 8'd0; bus.BRESP_M = 2'b00; bus.BVALID_M = 0;
      bus.ARREADY_M = 0;
      bus.RID_M = 8'd0; bus.RDATA_M = 32'd0; bus.RRESP_M = 2'b00;
      bus.RLAST_M = 0; bus.RVALID_M = 0;
      wr_valid = 0; wr_data = 32'd0; wr_strb = 4'd0; rd_ready = 1'b1;
      forever begin
         @(negedge ACLK);
         bus.ARREADY_M = bus.ARVALID_M && (ar_wait_cnt >= ar_delay);
         if (bus.ARVALID_M && ar_wait_cnt < ar_delay) ar_wait_cnt++;
         bus.AWREADY_M = bus.AWVALID_M && !aw_never && (aw_wait_cnt >= aw_delay);
         if (bus.AWVALID_M && aw_wait_cnt < aw_delay) aw_wait_cnt++;
         bus.RVALID_M = (r_pending > 0);
         bus.RDATA_M  = R_BASE + 32'(r_idx);
         bus.RLAST_M  = (r_pending == 1);
         bus.RRESP_M  = rresp_cfg;
         if (w_active) begin
            bus.WREADY_M = wready_toggle ? w_phase : 1'b1;
            w_phase      = ~w_phase;
         end else begin
            bus.WREADY_M = 1'b0;
            w_phase      = 1'b1;
         end
         bus.BVALID_M = b_pending;
         bus.BRESP_M  = bresp_cfg;
         wr_valid = (wr_idx < wr_total);
         wr_data  = 32'(32'h11 * (wr_idx + 1));
         wr_strb  = 4'hF;
         if (stall_left > 0 && r_consumed == stall_after) begin
            rd_ready = 1'b0;
            stall_left--;
         end else begin
            rd_ready = 1'b1;
         end
      end
   end

   // Monitor: samples mid-low-phase, values are those seen at the next rising edge.
   initial begin
      cyc = 0; done_cnt = 0; ar_pend_prev = 0;
      forever begin
         @(negedge ACLK);
         #2;
         cyc++;
         if (ARESET) begin
            ar_pend_prev = 0;
         end else begin
            if (req_valid && req_ready) begin
               accept_seen = 1; accept_cyc = cyc;
            end
            if (done) begin
               done_cnt++; done_cyc = cyc; done_err = resp_err; done_awvalid = bus.AWVALID_M;
            end
            if (ar_pend_prev && (!bus.ARVALID_M || bus.ARADDR_M !== ar_addr_prev ||
                                 bus.ARLEN_M !== ar_len_prev)) ar_stab_viol++;
            ar_pend_prev = bus.ARVALID_M && !bus.ARREADY_M;
            ar_addr_prev = bus.ARADDR_M;
            ar_len_prev  = bus.ARLEN_M;
            if (r_pending > 0 && bus.RREADY_M !== rd_ready) rr_viol++;
            if (bus.WVALID_M && !w_active) wv_viol++;
            if (b_pending && bus.BREADY_M !== 1'b1) bready_viol++;
            if (bus.RVALID_M && bus.RREADY_M) begin
               r_pending--; r_idx++;
            end
            if (rd_valid && rd_ready) begin
               beat_data_q.push_back(rd_data); beat_last_q.push_back(rd_last); r_consumed++;
            end
            if (bus.ARVALID_M && bus.ARREADY_M) begin
               addr_seen = bus.ARADDR_M; len_seen = bus.ARLEN_M;
               r_pending = int'(bus.ARLEN_M) + 1; r_idx = 0; ar_wait_cnt = 0;
            end
            if (bus.AWVALID_M && bus.AWREADY_M) begin
               addr_seen = bus.AWADDR_M; len_seen = bus.AWLEN_M;
               w_active = 1; aw_wait_cnt = 0;
            end
            if (bus.WVALID_M && bus.WREADY_M) begin
               beat_data_q.push_back(bus.WDATA_M); beat_last_q.push_back(bus.WLAST_M);
               strb_and = strb_and & bus.WSTRB_M;
               if (bus.WLAST_M) begin
                  w_active = 0; b_pending = 1;
               end
            end
            if (wr_valid && wr_ready) wr_idx++;
            if (bus.BVALID_M && bus.BREADY_M) b_pending = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected end of test");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      txn_vec_t vecs[6];
      bit       got_done;
      int       lat, start_cnt, last_pos, last_count;

      // Latency counts from the accept cycle: read 3+len, write 4+len.
      vecs[0] = '{1'b0, 32'h0000_0100, 4'd0, 2'b00, 2'b00, 1'b0, 3, 32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 32'h0000_0200, 4'd3, 2'b00, 2'b10, 1'b1, 7, 32'h0000_0044};
      vecs[2] = '{1'b0, 32'h0000_0300, 4'd0, 2'b00, 2'b00, 1'b0, 3, 32'hDEAD_BEEF};
      vecs[3] = '{1'b0, 32'h0000_1000, 4'd3, 2'b00, 2'b00, 1'b0, 6, 32'hDEAD_BEF2};
      vecs[4] = '{1'b1, 32'h0000_0040, 4'd0, 2'b00, 2'b00, 1'b0, 4, 32'h0000_0011};
      vecs[5] = '{1'b0, 32'h0000_0080, 4'd1, 2'b11, 2'b00, 1'b1, 4, 32'hDEAD_BEF0};

      clearSlave();
      req_valid = 0; req_write = 0; req_addr = 32'd0; req_len = 4'd0;
      ARESET = 1'b1;
      #1;
      checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_arvalid", 32'(bus.ARVALID_M), 32'd0);
      checkOutput("rst_awvalid", 32'(bus.AWVALID_M), 32'd0);
      checkOutput("rst_wvalid", 32'(bus.WVALID_M), 32'd0);
      checkOutput("rst_ready_outs", {28'd0, bus.BREADY_M, bus.RREADY_M, wr_ready, rd_valid}, 32'd0);
      checkOutput("rst_done_err", {30'd0, done, resp_err}, 32'd0);
      checkOutput("rst_araddr", bus.ARADDR_M, 32'd0);
      checkOutput("rst_wdata", bus.WDATA_M, 32'd0);
      checkOutput("const_arid", 32'(bus.ARID_M), 32'h03);
      checkOutput("const_awsize_burst", {27'd0, bus.AWSIZE_M, bus.AWBURST_M}, {27'd0, 3'b010, 2'b01});
      repeat (2) @(negedge ACLK);
      ARESET = 1'b0;
      #1;
      checkOutput("idle_req_ready", 32'(req_ready), 32'd1);

      for (int v = 0; v < 6; v++) begin
         clearSlave();
         rresp_cfg = vecs[v].rresp;
         bresp_cfg = vecs[v].bresp;
         start_cnt = done_cnt;
         applyStimulus(vecs[v].write, vecs[v].addr, vecs[v].len);
         waitDone(start_cnt, got_done, lat);
         repeat (2) @(negedge ACLK);
         checkOutput($sformatf("v%0d_done", v), 32'(got_done), 32'd1);
         checkOutput($sformatf("v%0d_done_pulses", v), 32'(done_cnt - start_cnt), 32'd1);
         checkOutput($sformatf("v%0d_latency", v), 32'(lat), 32'(vecs[v].exp_lat));
         checkOutput($sformatf("v%0d_resp_err", v), 32'(done_err), 32'(vecs[v].exp_err));
         checkOutput($sformatf("v%0d_addr", v), addr_seen, vecs[v].addr);
         checkOutput($sformatf("v%0d_len", v), 32'(len_seen), 32'(vecs[v].len));
         checkOutput($sformatf("v%0d_beats", v), 32'(beat_data_q.size()), 32'(int'(vecs[v].len) + 1));
         if (beat_data_q.size() > 0) begin
            checkOutput($sformatf("v%0d_last_data", v), beat_data_q[beat_data_q.size() - 1], vecs[v].exp_last);
         end
         last_pos = -1; last_count = 0;
         foreach (beat_last_q[i]) begin
            if (beat_last_q[i]) begin
               last_count++;
               if (last_pos < 0) last_pos = i;
            end
         end
         checkOutput($sformatf("v%0d_last_pos", v), 32'(last_pos), 32'(int'(vecs[v].len)));
         checkOutput($sformatf("v%0d_last_count", v), 32'(last_count), 32'd1);
      end

      // Burst write against a slave whose WREADY alternates 1,0,1,...
      clearSlave();
      wready_toggle = 1;
      start_cnt = done_cnt;
      applyStimulus(1'b1, 32'h0000_2000, 4'd3);
      waitDone(start_cnt, got_done, lat);
      checkOutput("wtog_done", 32'(got_done), 32'd1);
      checkOutput("wtog_latency", 32'(lat), 32'd10);
      checkOutput("wtog_resp_err", 32'(done_err), 32'd0);
      checkOutput("wtog_beats", 32'(beat_data_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < beat_data_q.size(); i++) begin
         checkOutput($sformatf("wtog_data%0d", i), beat_data_q[i], 32'(32'h11 * (i + 1)));
         checkOutput($sformatf("wtog_wlast%0d", i), 32'(beat_last_q[i]), 32'(i == 3));
      end
      checkOutput("wtog_strb", 32'(strb_and), 32'hF);
      checkOutput("wtog_w_before_aw", 32'(wv_viol), 32'd0);
      checkOutput("wtog_bready", 32'(bready_viol), 32'd0);

      // Read with AR held off 5 cycles and the consumer stalling 3 cycles on beat 1.
      clearSlave();
      ar_delay = 5; stall_after = 1; stall_left = 3;
      start_cnt = done_cnt;
      applyStimulus(1'b0, 32'h0000_3000, 4'd3);
      waitDone(start_cnt, got_done, lat);
      checkOutput("bp_done", 32'(got_done), 32'd1);
      checkOutput("bp_latency", 32'(lat), 32'd14);
      checkOutput("bp_resp_err", 32'(done_err), 32'd0);
      checkOutput("bp_ar_stable", 32'(ar_stab_viol), 32'd0);
      checkOutput("bp_rready_follows", 32'(rr_viol), 32'd0);
      checkOutput("bp_araddr", addr_seen, 32'h0000_3000);
      checkOutput("bp_beats", 32'(beat_data_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < beat_data_q.size(); i++) begin
         checkOutput($sformatf("bp_data%0d", i), beat_data_q[i], R_BASE + 32'(i));
      end

      // Timeout: AWREADY never comes; DONE 8 cycles after AW entry (9 after accept).
      clearSlave();
      aw_never = 1;
      start_cnt = done_cnt;
      applyStimulus(1'b1, 32'h0000_0500, 4'd0);
      waitDone(start_cnt, got_done, lat);
      #1;
      checkOutput("to_done", 32'(got_done), 32'd1);
      checkOutput("to_latency", 32'(lat), 32'd9);
      checkOutput("to_resp_err", 32'(done_err), 32'd1);
      checkOutput("to_awvalid_dropped", 32'(done_awvalid), 32'd0);
      checkOutput("to_req_ready", 32'(req_ready), 32'd1);
      checkOutput("to_no_beats", 32'(beat_data_q.size()), 32'd0);

      // Asynchronous reset while beat 2 of a 4-beat read is on the bus.
      clearSlave();
      start_cnt = done_cnt;
      applyStimulus(1'b0, 32'h0000_0600, 4'd3);
      begin
         int n;
         n = 0;
         while (r_consumed < 2 && n < 50) begin
            @(negedge ACLK);
            n++;
         end
      end
      checkOutput("rst_mid_reached_beat2", 32'(r_consumed), 32'd2);
      ARESET = 1'b1;
      r_pending = 0; w_active = 0; b_pending = 0;
      #1;
      checkOutput("rst_mid_rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("rst_mid_rready", 32'(bus.RREADY_M), 32'd0);
      checkOutput("rst_mid_rd_data", rd_data, 32'd0);
      checkOutput("rst_mid_araddr", bus.ARADDR_M, 32'd0);
      checkOutput("rst_mid_req_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_mid_done", 32'(done), 32'd0);
      repeat (2) @(negedge ACLK);
      ARESET = 1'b0;
      #1;
      checkOutput("rst_mid_req_ready_after", 32'(req_ready), 32'd1);
      repeat (5) @(negedge ACLK);
      checkOutput("rst_mid_no_done", 32'(done_cnt - start_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
